axi_write_scheduler: RTL
========================

Name: axi_write_scheduler

Overview:
Sequences AXI write transactions from NB_MASTER requesters onto NB_SLAVE address-mapped targets, one transaction in flight at a time. It does round-robin arbitration on AW requests and decodes the winning address against a start/end range table. It holds the master/slave routing until the W last beat and the B response complete, and flags decode errors. It is the control half of a lightweight write path; external muxes driven by its select outputs carry the AW/W/B payloads.

Parameters:
NB_MASTER, 3, number of requesting masters (2..8)
NB_SLAVE, 3, number of address-mapped targets (1..8)
AXI_ADDR_WIDTH, 32, address width
CNT_WIDTH, 16, width of completed-transaction counter

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  reset, asynchronous, active-low
mst_aw_valid_i  in  NB_MASTER  per-master AW request
mst_aw_addr_i  in  NB_MASTER*AXI_ADDR_WIDTH  per-master AW address, master i at slice i
mst_aw_ready_o  out  NB_MASTER  per-master AW accept
start_addr_i  in  NB_SLAVE*AXI_ADDR_WIDTH  inclusive range start, slave j at slice j
end_addr_i  in  NB_SLAVE*AXI_ADDR_WIDTH  inclusive range end
slv_aw_valid_o  out  1  AW valid toward selected slave
slv_aw_ready_i  in  1  AW ready from selected slave
w_last_hs_i  in  1  W beat with WLAST handshaked on routed path
b_hs_i  in  1  B response handshaked to granted master
mst_sel_o  out  NB_MASTER  one-hot granted master, 0 when idle
slv_sel_o  out  NB_SLAVE  one-hot target slave, 0 when idle or decode error
decerr_o  out  1  current transaction has no target (W sink + DECERR B)
busy_o  out  1  state != IDLE
txn_cnt_o  out  CNT_WIDTH  completed transactions, saturating

Behaviour:
- Reset (async assert, sync-to-clk release): state IDLE, rr pointer 0. All outputs 0: mst_aw_ready_o, slv_aw_valid_o, mst_sel_o, slv_sel_o, decerr_o, busy_o, txn_cnt_o.
- Reset mid-transaction abandons the transaction. No completion is counted.
- FSM states IDLE, ADDR, DATA, RESP.
- IDLE: when any mst_aw_valid_i is set, pick the first set bit scanning from rr pointer upward with wrap (index mod NB_MASTER). Register the winner index and decode its address. Next state ADDR. No ready is asserted in IDLE.
- Decode: slave j matches if start_j <= addr <= end_j, unsigned compare. Lowest matching j wins on overlap. No match gives decerr = 1.
- Decode result is registered at the IDLE->ADDR edge. Range inputs are ignored after that until the next IDLE.
- ADDR, normal: slv_aw_valid_o = 1. mst_aw_ready_o[winner] = slv_aw_ready_i, combinational pass-through. On slv_aw_ready_i go to DATA.
- ADDR, decerr: slv_aw_valid_o = 0. mst_aw_ready_o[winner] = 1 for exactly one cycle. Go to DATA.
- mst_sel_o and decerr_o are valid from ADDR through RESP. slv_sel_o is valid from ADDR through RESP when decerr = 0.
- DATA: wait for w_last_hs_i, then go to RESP. w_last_hs_i is ignored in every other state.
- RESP: wait for b_hs_i, then go to IDLE. In the same edge: rr pointer = (winner+1) mod NB_MASTER, and txn_cnt_o increments, saturating at all-ones. The decerr case counts too.
- b_hs_i outside RESP is ignored. w_last_hs_i and b_hs_i are never both in the same state, so no simultaneous-event conflict exists.
- Minimum latency: request at cycle 0 gives ADDR at cycle 1. AW handshake can occur at cycle 1. Earliest return to IDLE is 3 cycles after AW handshake with immediate W last and B.
- Winner mst_aw_valid_i dropping in ADDR is a protocol violation. An assertion in the bench checks it; RTL behaviour is undefined.
- Non-winning masters see mst_aw_ready_o = 0 throughout.

Test Plan:
- Single write: master1 addr 0x0010_0040, map {0x0-0xF_FFFF, 0x10_0000-0x1F_FFFF, 0x1A10_0000-0x1A11_FFFF}, slv_aw_ready_i=1 -> mst_sel_o=3'b010, slv_sel_o=3'b010, mst_aw_ready_o[1] pulse at cycle 1. After w_last_hs_i then b_hs_i: IDLE, txn_cnt_o=1.
- Round-robin fairness: all three masters valid continuously, each transaction completed -> grant order 0,1,2,0,1,2. No master is granted twice before the other two.
- Decode error: master0 addr 0x2000_0000 -> slv_aw_valid_o stays 0, mst_aw_ready_o[0] is one-cycle pulse, decerr_o=1, slv_sel_o=0. Completes after w_last/b; txn_cnt_o increments.
- Backpressure and edges: slv_aw_ready_i low 5 cycles -> state held in ADDR and mst_aw_ready_o=0 until ready. Addr 0x1A11_FFFF -> slave2; addr 0x000F_FFFF -> slave0; overlapping ranges -> lowest index.
- Stray handshakes: w_last_hs_i in RESP and b_hs_i in DATA -> no state change.
- Counter and reset: CNT_WIDTH=2, five transactions -> txn_cnt_o saturates at 3. rst_n pulsed low in DATA -> all outputs 0 immediately; next grant starts at master0.

Source files
------------

// File: rtl/axi_write_scheduler_if.sv
// AW handshake and routed-path completion strobes between the requesting
// masters, the selected slave and the write scheduler. Signal suffixes are
// written from the scheduler's point of view.
interface axi_write_scheduler_if #(
    parameter int NB_MASTER      = 3,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [NB_MASTER-1:0]                mst_aw_valid_i;
    logic [NB_MASTER*AXI_ADDR_WIDTH-1:0] mst_aw_addr_i;
    logic [NB_MASTER-1:0]                mst_aw_ready_o;
    logic                                slv_aw_valid_o;
    logic                                slv_aw_ready_i;
    logic                                w_last_hs_i;
    logic                                b_hs_i;

    // Scheduler side: takes requests and completion strobes, drives accepts.
    modport slave (
        input  mst_aw_valid_i,
        input  mst_aw_addr_i,
        input  slv_aw_ready_i,
        input  w_last_hs_i,
        input  b_hs_i,
        output mst_aw_ready_o,
        output slv_aw_valid_o
    );

    // Environment side: masters, target slave and the W/B datapath.
    modport master (
        output mst_aw_valid_i,
        output mst_aw_addr_i,
        output slv_aw_ready_i,
        output w_last_hs_i,
        output b_hs_i,
        input  mst_aw_ready_o,
        input  slv_aw_valid_o
    );
endinterface

// File: rtl/axi_write_scheduler.sv
// Write-path control: round-robin AW arbitration across masters, address
// range decode onto slaves, and routing held until WLAST and B complete.
// Only one transaction is in flight at a time.
module axi_write_scheduler #(
    parameter int NB_MASTER      = 3,
    parameter int NB_SLAVE       = 3,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    axi_write_scheduler_if.slave               bus,
    input  logic [NB_SLAVE*AXI_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVE*AXI_ADDR_WIDTH-1:0] end_addr_i,
    output logic [NB_MASTER-1:0]               mst_sel_o,
    output logic [NB_SLAVE-1:0]                slv_sel_o,
    output logic                               decerr_o,
    output logic                               busy_o,
    output logic [CNT_WIDTH-1:0]               txn_cnt_o
);
    localparam int MIDX_W = $clog2(NB_MASTER);
    localparam int AW     = AXI_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                 state_q, state_d;
    logic [MIDX_W-1:0]      rr_q, rr_d;
    logic [MIDX_W-1:0]      win_q, win_d;
    logic [NB_MASTER-1:0]   mst_sel_q, mst_sel_d;
    logic [NB_SLAVE-1:0]    slv_sel_q, slv_sel_d;
    logic                   decerr_q, decerr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   any_req;
    logic                   arb_found;
    logic [MIDX_W-1:0]      arb_idx;
    logic [MIDX_W:0]        cand;
    logic [AW-1:0]          win_addr;
    logic [NB_SLAVE-1:0]    slv_match;
    logic [NB_SLAVE-1:0]    dec_sel;
    logic                   start_txn;
    logic                   end_txn;

    assign any_req   = |bus.mst_aw_valid_i;
    assign start_txn = (state_q == IDLE) && any_req;
    assign end_txn   = (state_q == RESP) && bus.b_hs_i;

    // Round-robin pick: first requesting master at or above the pointer, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NB_MASTER; k++) begin
            cand = {1'b0, rr_q} + (MIDX_W+1)'(k);
            if (cand >= (MIDX_W+1)'(NB_MASTER)) begin
                cand = cand - (MIDX_W+1)'(NB_MASTER);
            end
            if (!arb_found && bus.mst_aw_valid_i[cand[MIDX_W-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[MIDX_W-1:0];
            end
        end
    end

    // Address of the master about to be granted.
    always_comb begin
        win_addr = '0;
        for (int m = 0; m < NB_MASTER; m++) begin
            if (arb_idx == MIDX_W'(m)) begin
                win_addr = bus.mst_aw_addr_i[m*AW +: AW];
            end
        end
    end

    // Per-slave inclusive range match, unsigned.
    genvar gi;
    generate
        for (gi = 0; gi < NB_SLAVE; gi++) begin : g_match
            assign slv_match[gi] = (win_addr >= start_addr_i[gi*AW +: AW]) &&
                                   (win_addr <= end_addr_i[gi*AW +: AW]);
        end
    endgenerate

    // Lowest matching slave wins when ranges overlap.
    always_comb begin
        dec_sel = '0;
        for (int j = NB_SLAVE - 1; j >= 0; j--) begin
            if (slv_match[j]) begin
                dec_sel    = '0;
                dec_sel[j] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion strobes only matter in their own state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ADDR;
            ADDR:    if (decerr_q || bus.slv_aw_ready_i) state_d = DATA;
            DATA:    if (bus.w_last_hs_i) state_d = RESP;
            RESP:    if (bus.b_hs_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Routing/decode capture at grant, release and bookkeeping at completion.
    always_comb begin
        rr_d      = rr_q;
        win_d     = win_q;
        mst_sel_d = mst_sel_q;
        slv_sel_d = slv_sel_q;
        decerr_d  = decerr_q;
        cnt_d     = cnt_q;
        if (start_txn) begin
            win_d     = arb_idx;
            mst_sel_d = NB_MASTER'(1) << arb_idx;
            slv_sel_d = dec_sel;
            decerr_d  = ~|slv_match;
        end
        if (end_txn) begin
            mst_sel_d = '0;
            slv_sel_d = '0;
            decerr_d  = 1'b0;
            rr_d      = (win_q == MIDX_W'(NB_MASTER - 1)) ? '0 : win_q + MIDX_W'(1);
            if (~&cnt_q) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            win_q     <= '0;
            mst_sel_q <= '0;
            slv_sel_q <= '0;
            decerr_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rr_q      <= rr_d;
            win_q     <= win_d;
            mst_sel_q <= mst_sel_d;
            slv_sel_q <= slv_sel_d;
            decerr_q  <= decerr_d;
            cnt_q     <= cnt_d;
        end
    end

    // AW handshake outputs: pass-through ready normally, a one-cycle accept
    // pulse for unmapped addresses (ADDR lasts exactly one cycle then).
    always_comb begin
        bus.mst_aw_ready_o = '0;
        bus.slv_aw_valid_o = 1'b0;
        if (state_q == ADDR) begin
            if (decerr_q) begin
                bus.mst_aw_ready_o = mst_sel_q;
            end else begin
                bus.slv_aw_valid_o = 1'b1;
                if (bus.slv_aw_ready_i) begin
                    bus.mst_aw_ready_o = mst_sel_q;
                end
            end
        end
    end

    assign mst_sel_o = mst_sel_q;
    assign slv_sel_o = slv_sel_q;
    assign decerr_o  = decerr_q;
    assign busy_o    = (state_q != IDLE);
    assign txn_cnt_o = cnt_q;

endmodule
